// File: rtl/serial_pattern_streamer.sv
// Loads a parallel pattern and streams it MSB-first on X at DIV clocks per bit,
// with a one-cycle bit_strobe per new bit and a start/busy/done handshake.
module serial_pattern_streamer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV   = 50000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WIDTH-1:0]         pattern,
    input  logic [$clog2(WIDTH):0]   len,
    output logic                     X,
    output logic                     bit_strobe,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned LenW = $clog2(WIDTH) + 1;
    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Shift = 2'd1,
        Done  = 2'd2
    } stateType;

    stateType         state;
    stateType         stateNext;
    logic [WIDTH-1:0] shiftReg;
    logic [WIDTH-1:0] shiftNext;
    logic [LenW-1:0]  bitCnt;
    logic [LenW-1:0]  bitCntNext;
    logic [DivW-1:0]  divCnt;
    logic [DivW-1:0]  divCntNext;
    logic             xNext;
    logic             strobeNext;
    logic             busyNext;
    logic             doneNext;

    logic [LenW-1:0]  effLen;
    logic [WIDTH-1:0] aligned;
    logic             lastDiv;
    logic             lastBit;

    // Out-of-range lengths clamp to the full width; the pattern is left-aligned
    // so the first bit to send always sits in the MSB of the shift register.
    always_comb begin
        effLen = len;
        if (len == '0 || len > LenW'(WIDTH)) begin
            effLen = LenW'(WIDTH);
        end
        aligned = pattern << (LenW'(WIDTH) - effLen);
    end

    assign lastDiv = (divCnt == DivW'(DIV - 1));
    assign lastBit = (bitCnt <= LenW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= Idle;
            shiftReg   <= '0;
            bitCnt     <= '0;
            divCnt     <= '0;
            X          <= 1'b0;
            bit_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= stateNext;
            shiftReg   <= shiftNext;
            bitCnt     <= bitCntNext;
            divCnt     <= divCntNext;
            X          <= xNext;
            bit_strobe <= strobeNext;
            busy       <= busyNext;
            done       <= doneNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            Idle:    if (start) stateNext = Shift;
            Shift:   if (lastDiv && lastBit) stateNext = Done;
            Done:    stateNext = Idle;
            default: stateNext = Idle;
        endcase
    end

    // Next values for the datapath and the registered outputs.
    always_comb begin
        shiftNext  = shiftReg;
        bitCntNext = bitCnt;
        divCntNext = divCnt;
        xNext      = X;
        strobeNext = 1'b0;
        busyNext   = 1'b0;
        doneNext   = 1'b0;
        case (state)
            Idle: begin
                xNext = 1'b0;
                if (start) begin
                    shiftNext  = aligned;
                    bitCntNext = effLen;
                    divCntNext = '0;
                    xNext      = aligned[WIDTH-1];
                    strobeNext = 1'b1;
                    busyNext   = 1'b1;
                end
            end
            Shift: begin
                busyNext = 1'b1;
                if (lastDiv) begin
                    divCntNext = '0;
                    if (!lastBit) begin
                        shiftNext  = shiftReg << 1;
                        xNext      = shiftReg[WIDTH-2];
                        strobeNext = 1'b1;
                        bitCntNext = bitCnt - LenW'(1);
                    end else begin
                        xNext      = 1'b0;
                        busyNext   = 1'b0;
                        doneNext   = 1'b1;
                        bitCntNext = '0;
                    end
                end else begin
                    divCntNext = divCnt + DivW'(1);
                end
            end
            Done: begin
                xNext = 1'b0;
            end
            default: begin
                xNext = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_streamer.sv
// Directed bench for serial_pattern_streamer: WIDTH=8/DIV=4 streams plus a
// DIV=1 instance with start held high for back-to-back replay.
module tb_serial_pattern_streamer;

    localparam int unsigned Width = 8;
    localparam int unsigned Div   = 4;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic       X;
    logic       bit_strobe;
    logic       busy;
    logic       done;

    logic       start2;
    logic [7:0] pattern2;
    logic [3:0] len2;
    logic       x2;
    logic       strobe2;
    logic       busy2;
    logic       done2;

    int checks;
    int errors;
    logic [7:0] seqBits;
    int strobeCount;

    serial_pattern_streamer #(.WIDTH(Width), .DIV(Div)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
        .X(X), .bit_strobe(bit_strobe), .busy(busy), .done(done)
    );

    serial_pattern_streamer #(.WIDTH(Width), .DIV(1)) dutFast (
        .clk(clk), .reset(reset), .start(start2), .pattern(pattern2), .len(len2),
        .X(x2), .bit_strobe(strobe2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one stream and compare every output each cycle against the
    // latency rules: bit k strobes at cycle 1+k*Div, done at 1+L*Div.
    task automatic runCheck(input string name, input logic [7:0] pat, input logic [3:0] ln,
                            input bit rePulse);
        int effL;
        int total;
        int k;
        logic expX, expS, expB, expD;
        effL = (ln == 0 || ln > Width) ? Width : int'(ln);
        total = effL * Div;
        pattern = pat;
        len = ln;
        start = 1'b1;
        seqBits = '0;
        strobeCount = 0;
        for (int c = 1; c <= total + 2; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            expB = (c <= total);
            expD = (c == total + 1);
            expS = expB && ((c - 1) % Div == 0);
            k = (c - 1) / Div;
            expX = expB ? pat[effL - 1 - k] : 1'b0;
            checkVal($sformatf("%s c%0d X", name, c), 32'(X), 32'(expX));
            checkVal($sformatf("%s c%0d strobe", name, c), 32'(bit_strobe), 32'(expS));
            checkVal($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(expB));
            checkVal($sformatf("%s c%0d done", name, c), 32'(done), 32'(expD));
            if (bit_strobe) begin
                seqBits = {seqBits[6:0], X};
                strobeCount++;
            end
            if (rePulse && (c == 2 || c == 19)) begin
                start = 1'b1;
                pattern = 8'hFF;
                len = 4'd8;
            end
            if (rePulse && (c == 3 || c == 20)) start = 1'b0;
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        start = 1'b0;
        pattern = '0;
        len = '0;
        start2 = 1'b0;
        pattern2 = '0;
        len2 = '0;

        #12;
        checkVal("reset X", 32'(X), 32'd0);
        checkVal("reset strobe", 32'(bit_strobe), 32'd0);
        checkVal("reset busy", 32'(busy), 32'd0);
        checkVal("reset done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Basic stream 010110, which a Moore 010110 detector would see once.
        runCheck("basic", 8'b00010110, 4'd6, 1'b0);
        checkVal("basic strobes", 32'(strobeCount), 32'd6);
        checkVal("basic sequence", 32'(seqBits[5:0]), 32'b010110);

        runCheck("clamp", 8'hA5, 4'd0, 1'b0);
        checkVal("clamp strobes", 32'(strobeCount), 32'd8);
        checkVal("clamp sequence", 32'(seqBits), 32'hA5);

        runCheck("busystart", 8'b00010110, 4'd6, 1'b1);
        checkVal("busystart strobes", 32'(strobeCount), 32'd6);

        // Asynchronous reset mid-stream, then a fresh short stream.
        pattern = 8'b00010110;
        len = 4'd6;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
        end
        checkVal("prereset busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkVal("midreset X", 32'(X), 32'd0);
        checkVal("midreset busy", 32'(busy), 32'd0);
        checkVal("midreset strobe", 32'(bit_strobe), 32'd0);
        checkVal("midreset done", 32'(done), 32'd0);
        tick();
        tick();
        checkVal("held reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        checkVal("postreset idle busy", 32'(busy), 32'd0);
        runCheck("afterreset", 8'b00000011, 4'd2, 1'b0);
        checkVal("afterreset sequence", 32'(seqBits[1:0]), 32'b11);

        // DIV=1 with start held: X=1,0,1 then DONE, IDLE, repeating every 5.
        pattern2 = 8'b00000101;
        len2 = 4'd3;
        start2 = 1'b1;
        for (int e = 0; e < 15; e++) begin
            logic ex, es, eb, ed;
            tick();
            case (e % 5)
                0: begin ex = 1'b1; es = 1'b1; eb = 1'b1; ed = 1'b0; end
                1: begin ex = 1'b0; es = 1'b1; eb = 1'b1; ed = 1'b0; end
                2: begin ex = 1'b1; es = 1'b1; eb = 1'b1; ed = 1'b0; end
                3: begin ex = 1'b0; es = 1'b0; eb = 1'b0; ed = 1'b1; end
                default: begin ex = 1'b0; es = 1'b0; eb = 1'b0; ed = 1'b0; end
            endcase
            checkVal($sformatf("b2b e%0d X", e), 32'(x2), 32'(ex));
            checkVal($sformatf("b2b e%0d strobe", e), 32'(strobe2), 32'(es));
            checkVal($sformatf("b2b e%0d busy", e), 32'(busy2), 32'(eb));
            checkVal($sformatf("b2b e%0d done", e), 32'(done2), 32'(ed));
        end
        start2 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
